// File: rtl/fir_pkg.sv
// Shared FIR sizing defaults, result type and the round/saturate helper.
// Latency: n/a (package; the helper is purely combinational).
// Backpressure: n/a.
package fir_pkg;

  // Default build of the serial FIR.
  localparam int DEF_FILTER_IN_BITS  = 16;
  localparam int DEF_COEFF_BITS      = 16;
  localparam int DEF_FILTER_OUT_BITS = 16;
  localparam int DEF_NUMBER_OF_TAPS  = 64;
  localparam int DEF_OUT_SHIFT       = 15;

  // Derived widths for the default build.
  // The accumulator carries log2(taps) guard bits over a full product, so a round cannot overflow.
  localparam int COUNTER_BITS = $clog2(DEF_NUMBER_OF_TAPS);
  localparam int PROD_BITS    = DEF_FILTER_IN_BITS + DEF_COEFF_BITS;
  localparam int ACC_BITS     = PROD_BITS + COUNTER_BITS;

  // The helper works on a fixed wide word.
  // Callers sign-extend into it and take the low out_bits of the value.
  localparam int RS_BITS = 64;
  typedef logic signed [RS_BITS-1:0] rs_word_t;

  typedef struct packed {
    logic     sat;
    rs_word_t value;
  } rs_t;

  // Round half up, arithmetic shift by 'shift', then clip to a signed out_bits range.
  // 'acc' must leave headroom for the rounding constant, i.e. fewer than RS_BITS significant bits.
  function automatic rs_t round_sat(input rs_word_t acc, input int shift, input int out_bits);
    rs_word_t rounded;
    rs_word_t hi;
    rs_word_t lo;
    rs_t      res;
    rounded   = (acc + (rs_word_t'(1) <<< (shift - 1))) >>> shift;
    hi        = (rs_word_t'(1) <<< (out_bits - 1)) - rs_word_t'(1);
    lo        = -(rs_word_t'(1) <<< (out_bits - 1));
    res.sat   = 1'b0;
    res.value = rounded;
    if (rounded > hi) begin
      res.value = hi;
      res.sat   = 1'b1;
    end else if (rounded < lo) begin
      res.value = lo;
      res.sat   = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_serial_mac_if.sv
// Tap-side inputs and filtered-sample outputs of the serial FIR MAC.
// Latency: n/a (wires only).
// Backpressure: none; the output is a valid pulse that the consumer must take.
// Ports: master = delay line / ROM / output consumer side, slave = the MAC.
interface fir_serial_mac_if #(
  parameter int FILTER_IN_BITS  = fir_pkg::DEF_FILTER_IN_BITS,
  parameter int COEFF_BITS      = fir_pkg::DEF_COEFF_BITS,
  parameter int FILTER_OUT_BITS = fir_pkg::DEF_FILTER_OUT_BITS,
  parameter int NUMBER_OF_TAPS  = fir_pkg::DEF_NUMBER_OF_TAPS
);
  localparam int COUNT_BITS = $clog2(NUMBER_OF_TAPS);

  logic                              phase_min;
  logic        [COUNT_BITS-1:0]      current_count;
  logic signed [FILTER_IN_BITS-1:0]  delay_filter_in;
  logic signed [COEFF_BITS-1:0]      coeff;
  logic signed [FILTER_OUT_BITS-1:0] filter_out;
  logic                              filter_out_valid;
  logic                              sat_flag;

  modport master (
    output phase_min, current_count, delay_filter_in, coeff,
    input  filter_out, filter_out_valid, sat_flag
  );

  modport slave (
    input  phase_min, current_count, delay_filter_in, coeff,
    output filter_out, filter_out_valid, sat_flag
  );

endinterface

// File: rtl/fir_round_sat.sv
// Combinational round-half-up, arithmetic shift and signed saturation of an accumulator.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: acc (IN_BITS signed) in; value (OUT_BITS signed) and sat (1 = value was clipped) out.
module fir_round_sat import fir_pkg::*; #(
  parameter int IN_BITS  = ACC_BITS,
  parameter int OUT_BITS = DEF_FILTER_OUT_BITS,
  parameter int SHIFT    = DEF_OUT_SHIFT
) (
  input  logic signed [IN_BITS-1:0]  acc,
  output logic signed [OUT_BITS-1:0] value,
  output logic                       sat
);

  rs_word_t acc_ext;
  rs_t      res;
  logic     unused_hi;

  always_comb begin
    acc_ext = rs_word_t'(acc);  // signed cast sign-extends into the wide word
    res     = round_sat(acc_ext, SHIFT, OUT_BITS);
  end

  // After clipping the value fits OUT_BITS, so the upper bits are only sign copies.
  assign value     = res.value[OUT_BITS-1:0];
  assign sat       = res.sat;
  assign unused_hi = ^res.value[RS_BITS-1:OUT_BITS];

endmodule

// File: rtl/fir_serial_mac.sv
// Serial FIR MAC: multiplies one tap per clock, sums a counter round, rounds/saturates to filter_out.
// Latency: filter_out_valid 2 cycles after the cycle with current_count == NUMBER_OF_TAPS-1.
// Backpressure: none; one valid pulse per round, filter_out is held until the next one.
// Ports: clk, rst_n (async, active low); bus (slave modport) carries phase_min, current_count,
//        delay_filter_in, coeff in and filter_out, filter_out_valid, sat_flag out.
module fir_serial_mac import fir_pkg::*; #(
  parameter int FILTER_IN_BITS  = DEF_FILTER_IN_BITS,
  parameter int COEFF_BITS      = DEF_COEFF_BITS,
  parameter int FILTER_OUT_BITS = DEF_FILTER_OUT_BITS,
  parameter int NUMBER_OF_TAPS  = DEF_NUMBER_OF_TAPS,
  parameter int OUT_SHIFT       = DEF_OUT_SHIFT
) (
  input logic             clk,
  input logic             rst_n,
  fir_serial_mac_if.slave bus
);

  // Widths for this instance.
  // The package counterparts describe the default build only.
  localparam int TAP_BITS = $clog2(NUMBER_OF_TAPS);
  localparam int MUL_BITS = FILTER_IN_BITS + COEFF_BITS;
  localparam int SUM_BITS = MUL_BITS + TAP_BITS;
  localparam logic [TAP_BITS-1:0] LAST_TAP = TAP_BITS'(NUMBER_OF_TAPS - 1);

  logic                              armed;
  logic                              prod_vld;
  logic signed [MUL_BITS-1:0]        prod_r;
  logic        [TAP_BITS-1:0]        tap_r;
  logic signed [SUM_BITS-1:0]        acc;
  logic signed [SUM_BITS-1:0]        prod_ext;
  logic signed [SUM_BITS-1:0]        sum;
  logic signed [FILTER_OUT_BITS-1:0] rs_value;
  logic                              rs_sat;
  logic signed [FILTER_OUT_BITS-1:0] filter_out_r;
  logic                              filter_out_valid_r;
  logic                              sat_flag_r;

  // Stage 1: register the product and its tap index.
  // prod_vld trails 'armed' by one clock, so the first accumulated tap is the
  // tap 0 that follows the arming phase_min.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed    <= 1'b0;
      prod_vld <= 1'b0;
      prod_r   <= '0;
      tap_r    <= '0;
    end else begin
      if (bus.phase_min) begin
        armed <= 1'b1;
      end
      prod_r   <= MUL_BITS'(bus.delay_filter_in) * MUL_BITS'(bus.coeff);
      tap_r    <= bus.current_count;
      prod_vld <= armed;
    end
  end

  assign prod_ext = SUM_BITS'(prod_r);  // sign extension
  assign sum      = acc + prod_ext;

  fir_round_sat #(
    .IN_BITS  (SUM_BITS),
    .OUT_BITS (FILTER_OUT_BITS),
    .SHIFT    (OUT_SHIFT)
  ) u_round_sat (
    .acc   (sum),
    .value (rs_value),
    .sat   (rs_sat)
  );

  // Stage 2: tap 0 restarts the sum, so back-to-back rounds need no clear cycle.
  // On the last tap the complete sum goes straight through round/saturate into the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc                <= '0;
      filter_out_r       <= '0;
      filter_out_valid_r <= 1'b0;
      sat_flag_r         <= 1'b0;
    end else begin
      filter_out_valid_r <= 1'b0;
      sat_flag_r         <= 1'b0;
      if (prod_vld) begin
        acc <= (tap_r == '0) ? prod_ext : sum;
        if (tap_r == LAST_TAP) begin
          filter_out_r       <= rs_value;
          filter_out_valid_r <= 1'b1;
          sat_flag_r         <= rs_sat;
        end
      end
    end
  end

  assign bus.filter_out       = filter_out_r;
  assign bus.filter_out_valid = filter_out_valid_r;
  assign bus.sat_flag         = sat_flag_r;

endmodule

// File: tb/tb_fir_serial_mac.sv
// Directed and random bench for fir_serial_mac with 4 taps, 16-bit data and OUT_SHIFT 15.
// The bench drives the tap counter and models the delay line and coefficient ROM.
// Ports: none (top-level bench).
module tb_fir_serial_mac;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fir_serial_mac_if #(
    .FILTER_IN_BITS  (16),
    .COEFF_BITS      (16),
    .FILTER_OUT_BITS (16),
    .NUMBER_OF_TAPS  (N)
  ) bus ();

  fir_serial_mac #(
    .FILTER_IN_BITS  (16),
    .COEFF_BITS      (16),
    .FILTER_OUT_BITS (16),
    .NUMBER_OF_TAPS  (N),
    .OUT_SHIFT       (15)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Delay line: hist[i] is the sample from i rounds ago; a new sample and a new
  // coefficient set take effect together when the counter wraps to 0.
  int   cnt;
  int   hist[N];
  int   coef[N];
  int   next_sample;
  int   next_coef[N];
  logic ovld;
  int   oout;
  logic osat;
  logic obs_vld[N];
  int   obs_out[N];
  logic obs_sat[N];

  task automatic drive();
    bus.current_count   = 2'(cnt);
    bus.phase_min       = (cnt == N - 1);
    bus.delay_filter_in = 16'(hist[cnt]);
    bus.coeff           = 16'(coef[cnt]);
  endtask

  // One clock: sample outputs 1 ns after the edge, then present the next count.
  task automatic step();
    @(posedge clk);
    #1;
    ovld = bus.filter_out_valid;
    oout = int'(bus.filter_out);
    osat = bus.sat_flag;
    cnt  = (cnt + 1) % N;
    if (cnt == 0) begin
      for (int i = N - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = next_sample;
      for (int i = 0; i < N; i++) coef[i] = next_coef[i];
    end
    drive();
  endtask

  // Presents counts 0..N-1 of one round. obs_*[k] holds the outputs seen while
  // count k is presented, so the previous round's result lands in slot 1.
  task automatic run_round(input int sample);
    next_sample = sample;
    for (int k = 0; k < N; k++) begin
      step();
      obs_vld[k] = ovld;
      obs_out[k] = oout;
      obs_sat[k] = osat;
    end
  endtask

  task automatic set_coef(input int c0, input int c1, input int c2, input int c3);
    next_coef[0] = c0;
    next_coef[1] = c1;
    next_coef[2] = c2;
    next_coef[3] = c3;
  endtask

  function automatic int rnd16(input bit big);
    logic [15:0] u;
    u = 16'($urandom);
    if (!big) u = {{6{u[9]}}, u[9:0]};
    return int'($signed(u));
  endfunction

  task automatic test_reset();
    cnt = 0;
    for (int i = 0; i < N; i++) begin
      hist[i] = 0;
      coef[i] = 0;
      next_coef[i] = 0;
    end
    next_sample = 0;
    drive();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.filter_out !== 16'sd0) begin
      errors++;
      $display("FAIL reset_out: got %0d expected 0", bus.filter_out);
    end
    checks++;
    if (bus.filter_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b expected 0", bus.filter_out_valid);
    end
    checks++;
    if (bus.sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_sat: got %b expected 0", bus.sat_flag);
    end
    step();
    step();
    rst_n = 1'b1;
    step();  // count 3 presented: this phase_min arms the MAC
    checks++;
    if (ovld !== 1'b0) begin
      errors++;
      $display("FAIL prearm_valid: got %b expected 0", ovld);
    end
  endtask

  task automatic test_zero_rounds();
    set_coef(100, 200, 300, 400);
    for (int r = 0; r < 4; r++) begin
      run_round(0);
      if (r == 0) begin
        checks++;
        if (obs_vld[1] !== 1'b0) begin
          errors++;
          $display("FAIL zero_first_valid: got %b expected 0", obs_vld[1]);
        end
      end else begin
        checks++;
        if (obs_vld[1] !== 1'b1 || obs_out[1] !== 0 || obs_sat[1] !== 1'b0) begin
          errors++;
          $display("FAIL zero_round%0d: got vld=%b out=%0d sat=%b expected vld=1 out=0 sat=0",
                   r, obs_vld[1], obs_out[1], obs_sat[1]);
        end
        checks++;
        if ({obs_vld[0], obs_vld[2], obs_vld[3]} !== 3'b000) begin
          errors++;
          $display("FAIL zero_pulse_width%0d: got %b%b%b expected 000",
                   r, obs_vld[0], obs_vld[2], obs_vld[3]);
        end
      end
    end
  endtask

  task automatic test_impulse();
    int exp_tbl[5];
    exp_tbl = '{500, 250, 125, 63, 0};
    set_coef(16384, 8192, 4096, 2048);
    for (int r = 0; r < 6; r++) begin
      run_round((r == 0) ? 1000 : 0);
      if (r >= 1) begin
        checks++;
        if (obs_vld[1] !== 1'b1 || obs_out[1] !== exp_tbl[r-1] || obs_sat[1] !== 1'b0) begin
          errors++;
          $display("FAIL impulse%0d: got vld=%b out=%0d sat=%b expected vld=1 out=%0d sat=0",
                   r - 1, obs_vld[1], obs_out[1], obs_sat[1], exp_tbl[r-1]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    set_coef(32767, 32767, 32767, 32767);
    for (int r = 0; r < 9; r++) begin
      run_round((r < 4) ? 32767 : ((r < 8) ? -32768 : 0));
      if (r == 1) begin
        checks++;
        if (obs_out[1] !== 32766 || obs_sat[1] !== 1'b0) begin
          errors++;
          $display("FAIL sat_partial: got out=%0d sat=%b expected out=32766 sat=0",
                   obs_out[1], obs_sat[1]);
        end
      end
      if (r == 4) begin
        checks++;
        if (obs_vld[1] !== 1'b1 || obs_out[1] !== 32767 || obs_sat[1] !== 1'b1) begin
          errors++;
          $display("FAIL sat_pos: got vld=%b out=%0d sat=%b expected vld=1 out=32767 sat=1",
                   obs_vld[1], obs_out[1], obs_sat[1]);
        end
      end
      if (r == 8) begin
        checks++;
        if (obs_vld[1] !== 1'b1 || obs_out[1] !== -32768 || obs_sat[1] !== 1'b1) begin
          errors++;
          $display("FAIL sat_neg: got vld=%b out=%0d sat=%b expected vld=1 out=-32768 sat=1",
                   obs_vld[1], obs_out[1], obs_sat[1]);
        end
        checks++;
        if (obs_sat[2] !== 1'b0) begin
          errors++;
          $display("FAIL sat_pulse_width: got %b expected 0", obs_sat[2]);
        end
      end
    end
  endtask

  task automatic test_reset_midround();
    set_coef(16384, 16384, 16384, 16384);
    for (int r = 0; r < 4; r++) run_round(100);
    next_sample = 100;
    step();
    step();
    checks++;
    if (ovld !== 1'b1 || oout !== 200) begin
      errors++;
      $display("FAIL pre_reset_out: got vld=%b out=%0d expected vld=1 out=200", ovld, oout);
    end
    step();  // count 2 presented
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.filter_out !== 16'sd0 || bus.filter_out_valid !== 1'b0 || bus.sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear: got out=%0d vld=%b sat=%b expected out=0 vld=0 sat=0",
               bus.filter_out, bus.filter_out_valid, bus.sat_flag);
    end
    step();  // count 3 presented while reset is still low for this edge
    rst_n = 1'b1;
    run_round(100);
    checks++;
    if ({obs_vld[0], obs_vld[1], obs_vld[2], obs_vld[3]} !== 4'b0000 || obs_out[1] !== 0) begin
      errors++;
      $display("FAIL broken_round: got vld=%b%b%b%b out=%0d expected vld=0000 out=0",
               obs_vld[0], obs_vld[1], obs_vld[2], obs_vld[3], obs_out[1]);
    end
    run_round(100);
    checks++;
    if (obs_vld[1] !== 1'b1 || obs_out[1] !== 200 || obs_sat[1] !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_round: got vld=%b out=%0d sat=%b expected vld=1 out=200 sat=0",
               obs_vld[1], obs_out[1], obs_sat[1]);
    end
  endtask

  task automatic test_random();
    longint s;
    longint rv;
    int     pe;
    logic   ps;
    bit     big;
    pe = 0;
    ps = 1'b0;
    for (int rd = 0; rd <= 1000; rd++) begin
      big = bit'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) next_coef[i] = (rd < 1000) ? rnd16(big) : 0;
      run_round((rd < 1000) ? rnd16(big) : 0);
      if (rd > 0) begin
        checks++;
        if (obs_vld[1] !== 1'b1 || obs_out[1] !== pe || obs_sat[1] !== ps) begin
          errors++;
          $display("FAIL random_round%0d: got vld=%b out=%0d sat=%b expected vld=1 out=%0d sat=%b",
                   rd - 1, obs_vld[1], obs_out[1], obs_sat[1], pe, ps);
        end
        checks++;
        if ({obs_vld[0], obs_vld[2], obs_vld[3]} !== 3'b000) begin
          errors++;
          $display("FAIL random_timing%0d: got %b%b%b expected 000",
                   rd - 1, obs_vld[0], obs_vld[2], obs_vld[3]);
        end
      end
      // Reference result for the round just presented.
      s = 0;
      for (int i = 0; i < N; i++) s += longint'(hist[i]) * longint'(coef[i]);
      rv = (s + 64'sd16384) >>> 15;
      ps = 1'b0;
      if (rv > 32767) begin
        rv = 32767;
        ps = 1'b1;
      end else if (rv < -32768) begin
        rv = -32768;
        ps = 1'b1;
      end
      pe = int'(rv);
    end
  endtask

  initial begin
    test_reset();
    test_zero_rounds();
    test_impulse();
    test_saturation();
    test_reset_midround();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion by time limit, expected completion");
    $fatal(1, "time limit reached");
  end

endmodule
